// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a shared async FIFO: grants one requester a
// burst of up to MAX_BURST words, only when the write-side count guarantees room.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic                          enable,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                          fifo_full,
  input  logic [ADDR_WIDTH:0]           fifo_count_wr_clk,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] BURST_MAX = (ADDR_WIDTH + 1)'(MAX_BURST);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  logic [0:0]            state_r;
  logic                  grant_valid_r;
  logic [ID_WIDTH-1:0]   grant_id_r;
  logic [ID_WIDTH-1:0]   ptr_r;
  logic [BEAT_W-1:0]     beat_r;

  logic [ADDR_WIDTH:0]   free_s;
  logic                  found_s;
  logic [ID_WIDTH-1:0]   next_id_s;
  logic                  start_s;
  logic                  own_valid_s;
  logic                  own_last_s;
  logic [DATA_WIDTH-1:0] own_data_s;
  logic                  wr_s;
  logic                  burst_end_s;

  // Count never exceeds depth, so this subtraction cannot wrap.
  assign free_s  = DEPTH - fifo_count_wr_clk;
  assign start_s = enable & found_s & (free_s >= BURST_MAX);

  assign own_valid_s = req_valid[grant_id_r];
  assign own_last_s  = req_last[grant_id_r];
  assign own_data_s  = req_data[int'(grant_id_r) * DATA_WIDTH +: DATA_WIDTH];

  assign wr_s        = grant_valid_r & own_valid_s & ~fifo_full;
  assign burst_end_s = (wr_s & (own_last_s | (beat_r == LAST_BEAT))) | ~own_valid_s;

  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

  // Round-robin search: first valid requester above the pointer, wrapping.
  always_comb begin
    int idx;
    found_s   = 1'b0;
    next_id_s = {ID_WIDTH{1'b0}};
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_r) + k) % N_REQ;
      if (!found_s && req_valid[idx]) begin
        found_s   = 1'b1;
        next_id_s = ID_WIDTH'(idx);
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Write datapath, gated by the registered grant so reset silences it at once.
  always_comb begin
    req_ready    = {N_REQ{1'b0}};
    fifo_wr_en   = 1'b0;
    fifo_wr_data = {(ID_WIDTH + DATA_WIDTH){1'b0}};
    if (grant_valid_r) begin
      req_ready[grant_id_r] = ~fifo_full;
      fifo_wr_en            = wr_s;
      fifo_wr_data          = {grant_id_r, own_data_s};
    end else begin
      fifo_wr_en            = 1'b0;
    end
  end

  // Grant FSM, beat counter and round-robin pointer.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_r       <= IDLE;
      grant_valid_r <= 1'b0;
      grant_id_r    <= {ID_WIDTH{1'b0}};
      ptr_r         <= ID_WIDTH'(N_REQ - 1);
      beat_r        <= {BEAT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r       <= BURST;
            grant_valid_r <= 1'b1;
            grant_id_r    <= next_id_s;
            ptr_r         <= next_id_s;
            beat_r        <= {BEAT_W{1'b0}};
          end
        end
        BURST: begin
          if (wr_s) begin
            beat_r <= beat_r + BEAT_W'(1);
          end
          if (burst_end_s) begin
            state_r       <= IDLE;
            grant_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          grant_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: grant order, burst length, space gating,
// early termination, full back-pressure, reset abort and enable gating.
module tb_fifo_wr_arbiter;

  logic        wr_clk;
  logic        wr_rst_n;
  logic        enable;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [17:0] fifo_wr_data;
  logic        fifo_full;
  logic [4:0]  fifo_count_wr_clk;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int tests  = 0;
  int failed = 0;

  fifo_wr_arbiter #(
    .N_REQ(4), .ID_WIDTH(2), .DATA_WIDTH(16), .ADDR_WIDTH(4), .MAX_BURST(4)
  ) dut (
    .wr_clk            (wr_clk),
    .wr_rst_n          (wr_rst_n),
    .enable            (enable),
    .req_valid         (req_valid),
    .req_last          (req_last),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .fifo_wr_en        (fifo_wr_en),
    .fifo_wr_data      (fifo_wr_data),
    .fifo_full         (fifo_full),
    .fifo_count_wr_clk (fifo_count_wr_clk),
    .grant_valid       (grant_valid),
    .grant_id          (grant_id)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  function automatic logic [17:0] exp_data(input int id);
    logic [1:0]  idb;
    logic [15:0] pay;
    idb = id[1:0];
    pay = 16'hC000 + 16'(id) * 16'h0111;
    return {idb, pay};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks outputs drop immediately, releases between edges.
  task automatic do_reset(input string tag);
    wr_rst_n = 1'b0;
    #1;
    chk({tag, "_gv"},      32'(grant_valid),  32'd0);
    chk({tag, "_gid"},     32'(grant_id),     32'd0);
    chk({tag, "_ready"},   32'(req_ready),    32'd0);
    chk({tag, "_wr_en"},   32'(fifo_wr_en),   32'd0);
    chk({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
    @(posedge wr_clk);
    #2;
    wr_rst_n = 1'b1;
  endtask

  // Called just after the edge that raised the grant; checks n writes then the bubble.
  task automatic expect_burst(input string tag, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      chk({tag, "_gv"},      32'(grant_valid),  32'd1);
      chk({tag, "_gid"},     32'(grant_id),     32'(id));
      chk({tag, "_ready"},   32'(req_ready),    32'(1 << id));
      chk({tag, "_wr_en"},   32'(fifo_wr_en),   32'd1);
      chk({tag, "_wr_data"}, 32'(fifo_wr_data), 32'(exp_data(id)));
      tick();
    end
    chk({tag, "_bubble_gv"},    32'(grant_valid), 32'd0);
    chk({tag, "_bubble_ready"}, 32'(req_ready),   32'd0);
    chk({tag, "_bubble_wr_en"}, 32'(fifo_wr_en),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    wr_rst_n          = 1'b1;
    enable            = 1'b1;
    req_valid         = 4'b0000;
    req_last          = 4'b0000;
    fifo_full         = 1'b0;
    fifo_count_wr_clk = 5'd0;
    for (int i = 0; i < 4; i++) begin
      req_data[i*16 +: 16] = 16'hC000 + 16'(i) * 16'h0111;
    end
    #1;

    // 1: single requester 2, back-to-back bursts with a one-cycle bubble.
    req_valid = 4'b0100;
    do_reset("t1_reset");
    chk("t1_idle_after_reset", 32'(grant_valid), 32'd0);
    tick();
    expect_burst("t1_burst", 2, 4);
    tick();
    chk("t1_regrant_gv",  32'(grant_valid), 32'd1);
    chk("t1_regrant_gid", 32'(grant_id),    32'd2);
    req_valid = 4'b0000;
    #1;
    chk("t1_release_wr_en", 32'(fifo_wr_en), 32'd0);
    tick();
    chk("t1_release_gv", 32'(grant_valid), 32'd0);

    // 2: everyone requesting, round-robin from requester 0.
    req_valid = 4'b1111;
    do_reset("t2_reset");
    tick();
    expect_burst("t2_g0", 0, 4);
    tick();
    expect_burst("t2_g1", 1, 4);
    tick();
    expect_burst("t2_g2", 2, 4);
    tick();
    expect_burst("t2_g3", 3, 4);
    tick();
    expect_burst("t2_g0b", 0, 4);
    req_valid = 4'b0000;

    // 3: three free slots is not enough for a 4-word burst; four is.
    req_valid         = 4'b0010;
    fifo_count_wr_clk = 5'd13;
    tick();
    chk("t3_nospace_a", 32'(grant_valid), 32'd0);
    tick();
    chk("t3_nospace_b", 32'(grant_valid), 32'd0);
    fifo_count_wr_clk = 5'd12;
    tick();
    expect_burst("t3_burst", 1, 4);
    req_valid         = 4'b0000;
    fifo_count_wr_clk = 5'd0;

    // 4a: req_last on the second beat ends the burst after two writes.
    req_valid = 4'b0001;
    tick();
    chk("t4_gid",    32'(grant_id),   32'd0);
    chk("t4_beat1",  32'(fifo_wr_en), 32'd1);
    tick();
    req_last = 4'b0001;
    #1;
    chk("t4_beat2",  32'(fifo_wr_en), 32'd1);
    tick();
    chk("t4_last_end_gv", 32'(grant_valid), 32'd0);
    // 4b: next grant goes to the next valid requester after 0, then it drops valid.
    req_last  = 4'b0000;
    req_valid = 4'b0101;
    tick();
    chk("t4_next_gid",   32'(grant_id),   32'd2);
    chk("t4_next_wr_en", 32'(fifo_wr_en), 32'd1);
    tick();
    req_valid = 4'b0001;
    #1;
    chk("t4_drop_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t4_drop_ready", 32'(req_ready),  32'd4);
    tick();
    chk("t4_drop_end_gv", 32'(grant_valid), 32'd0);
    req_valid = 4'b0000;

    // 5: full for three cycles after the first beat; burst still totals four writes.
    req_valid = 4'b1000;
    tick();
    chk("t5_gid",   32'(grant_id),   32'd3);
    chk("t5_beat1", 32'(fifo_wr_en), 32'd1);
    tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t5_full_wr_en", 32'(fifo_wr_en),  32'd0);
      chk("t5_full_ready", 32'(req_ready),   32'd0);
      chk("t5_full_gv",    32'(grant_valid), 32'd1);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    expect_burst("t5_rest", 3, 3);
    req_valid = 4'b0000;

    // 6a: reset during the second beat of requester 3's burst aborts it.
    req_valid = 4'b1000;
    tick();
    chk("t6_gid", 32'(grant_id), 32'd3);
    tick();
    chk("t6_beat2", 32'(fifo_wr_en), 32'd1);
    req_valid = 4'b1111;
    do_reset("t6_abort");
    tick();
    chk("t6_first_gid", 32'(grant_id),    32'd0);
    chk("t6_first_gv",  32'(grant_valid), 32'd1);
    // 6b: enable dropped mid-burst lets it finish but starts nothing new.
    enable = 1'b0;
    #1;
    expect_burst("t6_en_low", 0, 4);
    tick();
    chk("t6_disabled_a", 32'(grant_valid), 32'd0);
    tick();
    chk("t6_disabled_b", 32'(grant_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side arbiter that shares one fifo_asynch_count write port among N_REQ requesters in the wr_clk domain. It grants the port to one requester at a time for a burst of up to MAX_BURST words, using round-robin order. A burst starts only when the FIFO's write-domain occupancy count guarantees room for the whole burst. Each written word carries the source ID in its upper bits, so the read side can demultiplex.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_WIDTH, 2, source-ID field width; must satisfy 2^ID_WIDTH >= N_REQ
DATA_WIDTH, 16, payload width per requester
ADDR_WIDTH, 4, ADDR_WIDTH of the attached FIFO; depth = 2^ADDR_WIDTH
MAX_BURST, 4, maximum words per grant; 1 <= MAX_BURST <= 2^ADDR_WIDTH

Ports:
wr_clk  in  1  write-domain clock
wr_rst_n  in  1  asynchronous active-low reset
enable  in  1  when low, no new burst starts; an active burst completes normally
req_valid  in  N_REQ  per-requester word valid
req_last  in  N_REQ  per-requester end-of-burst marker, qualified by that requester's valid
req_data  in  N_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  N_REQ  per-requester accept
fifo_wr_en  out  1  to FIFO wr_en
fifo_wr_data  out  ID_WIDTH+DATA_WIDTH  to FIFO wr_data, formatted {grant_id, payload}
fifo_full  in  1  from FIFO full
fifo_count_wr_clk  in  ADDR_WIDTH+1  from FIFO write-domain occupancy
grant_valid  out  1  a burst is active
grant_id  out  ID_WIDTH  requester that owns the current burst

Behaviour:
- Reset (asynchronous, wr_rst_n low):
  - State = IDLE; grant_valid=0, grant_id=0, beat counter=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - req_ready, fifo_wr_en and fifo_wr_data are all 0 immediately, because they are gated by grant_valid.
  - A reset during a burst aborts it with no further writes.
- Free space: free = 2^ADDR_WIDTH - fifo_count_wr_clk, computed at ADDR_WIDTH+1 bits; fifo_count_wr_clk never exceeds 2^ADDR_WIDTH. The write-domain count is conservative because the read pointer lags, so it is safe to trust.
- FSM states: IDLE, BURST.
- IDLE: when enable=1, free >= MAX_BURST and any req_valid is high:
  - Select the first requester with valid high, searching upward from pointer+1 modulo N_REQ.
  - Register grant_id to that requester, set grant_valid=1, clear the beat counter, enter BURST.
  - Pointer <= the selected index.
  - The grant is registered, so a request seen in IDLE cycle N can first be written in cycle N+1.
- BURST (combinational datapath):
  - req_ready[i] = (i == grant_id) & !fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & req_ready[grant_id].
  - fifo_wr_data = {grant_id, req_data[grant_id]} while grant_valid, else 0.
  - Each write increments the beat counter (width clog2(MAX_BURST+1)).
- BURST ends, returning to IDLE with grant_valid=0 on the next edge, when any of these hold:
  - (a) a write occurs with req_last[grant_id]=1;
  - (b) a write brings the beat count to MAX_BURST;
  - (c) req_valid[grant_id]=0, meaning the requester released the grant.
- fifo_full high in BURST: ready and wr_en are held low, the beat counter holds, and the state is unchanged. This is a safety path only and should not occur given the space gating.
- Every burst is followed by at least one IDLE cycle (arbitration bubble). Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- enable falling during BURST has no effect until the burst ends.
- req_ready never asserts for a requester that does not own the grant. The arbiter never writes to the FIFO while fifo_full=1.

Test Plan:
1. Defaults; only req_valid[2]=1 held high, req_last=0, count=0 → grant_id=2 one cycle later; 4 writes with fifo_wr_data[17:16]=2; 1 IDLE cycle; grant 2 again.
2. All four requesters valid continuously, count=0 → grant order 0,1,2,3,0; each burst is 4 beats followed by a 1-cycle bubble; req_ready is one-hot or zero at all times.
3. count=13 (free 3), req_valid[1]=1 → no grant; count forced to 12 → grant to 1 on the next edge; 4 writes.
4. req_valid[0]=1 with req_last asserted on beat 2 → exactly 2 writes; next grant goes to the next valid requester. Separately, dropping req_valid mid-burst after 1 beat → grant released next edge.
5. fifo_full=1 for 3 cycles after beat 1 → wr_en=0 and ready=0 for those cycles, beat count held; remaining 3 beats complete afterward, 4 total.
6. wr_rst_n pulsed low during beat 2 of a burst by requester 3 → all outputs 0 immediately; after release with all requesters valid, the first grant goes to 0. Separately, enable=0 with requests pending → no grant.
